// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy front end: lane FSM state
// encoding and the default debounce/timeout constants.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E1    = 3'd1,
        ST_E2    = 3'd2,
        ST_E3    = 3'd3,
        ST_X1    = 3'd4,
        ST_X2    = 3'd5,
        ST_X3    = 3'd6,
        ST_ABORT = 3'd7
    } lane_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

    // True for the mid-crossing states, where the timeout applies.
    function automatic logic is_crossing(input lane_state_e s);
        return (s != ST_IDLE) && (s != ST_ABORT);
    endfunction

endpackage

// File: rtl/lane_sensor_decoder_if.sv
// Lane sensor bundle: raw loop inputs in, crossing pulses and status out.
interface lane_sensor_decoder_if;

    logic loop_a;
    logic loop_b;
    logic entry;
    logic exit;
    logic busy;
    logic fault;

    // Sensor side / consumer of the decoded events.
    modport master (
        output loop_a,
        output loop_b,
        input  entry,
        input  exit,
        input  busy,
        input  fault
    );

    // Decoder side.
    modport slave (
        input  loop_a,
        input  loop_b,
        output entry,
        output exit,
        output busy,
        output fault
    );

endinterface

// File: rtl/loop_debounce.sv
// One inductive loop: 2-flop synchronizer followed by a counting debouncer.
// level_next is the value the debounced register loads on the coming edge,
// so a consumer registering from it moves on the same edge as the level.
module loop_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count cycles the synced input disagrees with the level; flip on the last one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounced level and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_next = level_d;

endmodule

// File: rtl/lane_sensor_decoder.sv
// Lane crossing decoder: debounces both loops and tracks the crossing order
// to emit single-cycle entry/exit pulses, aborting on implausible sequences.
module lane_sensor_decoder
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lane_sensor_decoder_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]  loop_raw;
    logic [1:0]  deb_next;
    logic        a;
    logic        b;

    lane_state_e state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        entry_q, entry_d;
    logic        exit_q, exit_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;

    assign loop_raw = {bus.loop_b, bus.loop_a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_deb
            loop_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw_in     (loop_raw[gi]),
                .level_next (deb_next[gi])
            );
        end
    endgenerate

    assign a = deb_next[0];
    assign b = deb_next[1];

    // Next state from the debounced pair, then timeout override and output flags.
    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        fault_d = fault_q;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE: case ({a, b})
                2'b10:   state_d = ST_E1;
                2'b01:   state_d = ST_X1;
                2'b11:   state_d = ST_ABORT;
                default: state_d = ST_IDLE;
            endcase
            ST_E1: case ({a, b})
                2'b11:   state_d = ST_E2;
                2'b00:   state_d = ST_IDLE;
                2'b01:   state_d = ST_ABORT;
                default: state_d = ST_E1;
            endcase
            ST_E2: case ({a, b})
                2'b01:   state_d = ST_E3;
                2'b10:   state_d = ST_E1;
                2'b00:   state_d = ST_ABORT;
                default: state_d = ST_E2;
            endcase
            ST_E3: case ({a, b})
                2'b00: begin
                    state_d = ST_IDLE;
                    entry_d = 1'b1;
                end
                2'b11:   state_d = ST_E2;
                2'b10:   state_d = ST_ABORT;
                default: state_d = ST_E3;
            endcase
            ST_X1: case ({a, b})
                2'b11:   state_d = ST_X2;
                2'b00:   state_d = ST_IDLE;
                2'b10:   state_d = ST_ABORT;
                default: state_d = ST_X1;
            endcase
            ST_X2: case ({a, b})
                2'b10:   state_d = ST_X3;
                2'b01:   state_d = ST_X1;
                2'b00:   state_d = ST_ABORT;
                default: state_d = ST_X2;
            endcase
            ST_X3: case ({a, b})
                2'b00: begin
                    state_d = ST_IDLE;
                    exit_d  = 1'b1;
                end
                2'b11:   state_d = ST_X2;
                2'b01:   state_d = ST_ABORT;
                default: state_d = ST_X3;
            endcase
            default: state_d = ({a, b} == 2'b00) ? ST_IDLE : ST_ABORT;
        endcase

        // A crossing that sits in one state too long is abandoned with a fault.
        if (is_crossing(state_q) && (state_d == state_q)) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_ABORT;
                fault_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (state_d == ST_IDLE) begin
            fault_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign bus.entry = entry_q;
    assign bus.exit  = exit_q;
    assign bus.busy  = busy_q;
    assign bus.fault = fault_q;

endmodule
